// File: rtl/seg_dist_ctrl_if.sv
// Sample/display bundle between the distance path, the controller and the
// seven-segment scan driver. The master side produces samples and consumes
// the digit set. The slave side is the controller.
interface seg_dist_ctrl_if #(
  parameter int DIN_W = 19
);
  logic [DIN_W-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic [23:0]      digits;
  logic             digits_upd;
  logic             oor;
  logic             busy;

  modport master (
    output din, din_valid,
    input  din_ready, digits, digits_upd, oor, busy
  );

  modport slave (
    input  din, din_valid,
    output din_ready, digits, digits_upd, oor, busy
  );
endinterface

// File: rtl/seg_dist_ctrl.sv
// seg_dist_ctrl: rate-limited distance-to-BCD display controller.
// Accepts a 19-bit sample (0.01 mm/LSB) at most once per hold period.
// Converts the sample to six BCD digits with a sequential double-dabble.
// Presents a registered digit set that changes on a single edge.
// Optional build macro: SEG_DIST_LZ_BLANK_EN blanks the leading zeros in
// the two most significant digits of in-range results.
module seg_dist_ctrl #(
  parameter int HOLD_CYCLES = 5_000_000,
  parameter int MAX_VAL     = 400000,
  parameter int DIN_W       = 19
) (
  input  logic          clk,
  input  logic          rst_n,
  seg_dist_ctrl_if.slave bus
);

  localparam int               CNT_W     = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [4:0]       ITER_LAST = 5'(DIN_W - 1);
  localparam logic [31:0]      MAX_U     = MAX_VAL;
  localparam logic [23:0]      DASHES    = 24'hEEEEEE;

  typedef enum logic [1:0] {
    S_HOLD,
    S_IDLE,
    S_CONV,
    S_DONE
  } state_t;

  state_t           state_q,    state_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [4:0]       iter_q,     iter_d;
  logic [DIN_W-1:0] bin_q,      bin_d;
  logic [23:0]      bcd_q,      bcd_d;
  logic [23:0]      digits_q,   digits_d;
  logic             oor_q,      oor_d;

  logic [23:0]      bcd_adj;
  logic [23:0]      bcd_shift;
  logic [DIN_W-1:0] bin_shift;
  logic [23:0]      conv_result;
  logic             din_oor;

  // Double-dabble step: add 3 to every nibble >= 5, then shift {bcd, bin} left.
  generate
    for (genvar gi = 0; gi < 6; gi++) begin : g_adj
      assign bcd_adj[gi*4 +: 4] = (bcd_q[gi*4 +: 4] >= 4'd5) ? bcd_q[gi*4 +: 4] + 4'd3
                                                             : bcd_q[gi*4 +: 4];
    end
  endgenerate

  assign bcd_shift = {bcd_adj[22:0], bin_q[DIN_W-1]};
  assign bin_shift = {bin_q[DIN_W-2:0], 1'b0};
  assign din_oor   = 32'(bus.din) > MAX_U;

`ifdef SEG_DIST_LZ_BLANK_EN
  // Blank leading zeros in the two top digits. The cm-units digit always shows.
  always_comb begin
    conv_result = bcd_shift;
    if (bcd_shift[23:20] == 4'd0) begin
      conv_result[23:20] = 4'hF;
      if (bcd_shift[19:16] == 4'd0) begin
        conv_result[19:16] = 4'hF;
      end
    end
  end
`else
  assign conv_result = bcd_shift;
`endif

  // State and datapath registers; reset discards any conversion in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_HOLD;
      hold_cnt_q <= '0;
      iter_q     <= '0;
      bin_q      <= '0;
      bcd_q      <= '0;
      digits_q   <= DASHES;
      oor_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      iter_q     <= iter_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      digits_q   <= digits_d;
      oor_q      <= oor_d;
    end
  end

  // Next-state logic. Handshake and status outputs depend only on the state.
  // The digit register is loaded on the edge that enters DONE, so the new
  // value and digits_upd appear together for the one DONE cycle.
  always_comb begin
    state_d        = state_q;
    hold_cnt_d     = hold_cnt_q;
    iter_d         = iter_q;
    bin_d          = bin_q;
    bcd_d          = bcd_q;
    digits_d       = digits_q;
    oor_d          = oor_q;
    bus.din_ready  = 1'b0;
    bus.digits_upd = 1'b0;
    bus.busy       = 1'b0;

    case (state_q)
      S_HOLD: begin
        if (hold_cnt_q == HOLD_LAST) begin
          state_d = S_IDLE;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end

      S_IDLE: begin
        bus.din_ready = 1'b1;
        if (bus.din_valid) begin
          bin_d  = bus.din;
          bcd_d  = '0;
          iter_d = '0;
          if (din_oor) begin
            oor_d    = 1'b1;
            digits_d = DASHES;
            state_d  = S_DONE;
          end else begin
            oor_d   = 1'b0;
            state_d = S_CONV;
          end
        end
      end

      S_CONV: begin
        bus.busy = 1'b1;
        bin_d    = bin_shift;
        bcd_d    = bcd_shift;
        iter_d   = iter_q + 5'd1;
        if (iter_q == ITER_LAST) begin
          digits_d = conv_result;
          state_d  = S_DONE;
        end
      end

      S_DONE: begin
        bus.busy       = 1'b1;
        bus.digits_upd = 1'b1;
        hold_cnt_d     = '0;
        state_d        = S_HOLD;
      end

      default: state_d = S_HOLD;
    endcase
  end

  assign bus.digits = digits_q;
  assign bus.oor    = oor_q;

endmodule
